// File: rtl/gray_counter_param.sv
// Parametrised up/down Gray-code counter.
// Holds a binary count and registers both the binary and Gray views on the
// same edge. Supports synchronous load of a Gray value, wrap or saturate at
// the terminal counts, sticky overflow/underflow flags and a one-cycle pulse
// on each terminal event.
module gray_counter_param #(
    parameter int WIDTH     = 4,
    parameter bit WRAP      = 1'b1,
    parameter int RESET_VAL = 0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic             Up,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadGray,
    input  logic             ClrFlags,
    output logic [WIDTH-1:0] Output,
    output logic [WIDTH-1:0] Binary,
    output logic             Overflow,
    output logic             Underflow,
    output logic             Wrap
);

    localparam logic [WIDTH-1:0] MAX     = '1;
    localparam logic [WIDTH-1:0] RV_BIN  = RESET_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RV_GRAY = RV_BIN ^ (RV_BIN >> 1);

    // Prefix XOR from the MSB down turns a Gray code back into binary.
    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_ovf;
    logic             r_unf;
    logic             r_wrap;

    logic [WIDTH-1:0] w_bin_nxt;
    logic [WIDTH-1:0] w_gray_nxt;
    logic             w_term_up;
    logic             w_term_dn;
    logic             w_set_ovf;
    logic             w_set_unf;

    // A load overrides a terminal step, so it also suppresses flag set and pulse.
    assign w_term_up = En & Up & (r_bin == MAX);
    assign w_term_dn = En & ~Up & (r_bin == '0);
    assign w_set_ovf = ~Load & w_term_up;
    assign w_set_unf = ~Load & w_term_dn;

    // Next binary count: load first, then terminal handling, then a plain step.
    always_comb begin
        w_bin_nxt = r_bin;
        if (Load) begin
            w_bin_nxt = gray2bin(LoadGray);
        end else if (w_term_up) begin
            w_bin_nxt = WRAP ? '0 : MAX;
        end else if (w_term_dn) begin
            w_bin_nxt = WRAP ? MAX : '0;
        end else if (En) begin
            w_bin_nxt = Up ? r_bin + WIDTH'(1) : r_bin - WIDTH'(1);
        end
    end

    // Gray view is derived from the next binary value so both registers agree.
    always_comb begin
        w_gray_nxt = w_bin_nxt ^ (w_bin_nxt >> 1);
        if (Load) begin
            w_gray_nxt = LoadGray;
        end
    end

    // State registers; a flag set in the same cycle as ClrFlags wins.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_bin  <= RV_BIN;
            r_gray <= RV_GRAY;
            r_ovf  <= 1'b0;
            r_unf  <= 1'b0;
            r_wrap <= 1'b0;
        end else begin
            r_bin  <= w_bin_nxt;
            r_gray <= w_gray_nxt;
            r_ovf  <= w_set_ovf | (r_ovf & ~ClrFlags);
            r_unf  <= w_set_unf | (r_unf & ~ClrFlags);
            r_wrap <= w_set_ovf | w_set_unf;
        end
    end

    assign Output    = r_gray;
    assign Binary    = r_bin;
    assign Overflow  = r_ovf;
    assign Underflow = r_unf;
    assign Wrap      = r_wrap;

endmodule

// File: tb/tb_gray_counter_param.sv
// Bench for gray_counter_param: three instances share one stimulus stream
// (3-bit wrap, 3-bit saturate with preset 2, 8-bit wrap). An arithmetic
// model is compared every cycle; directed literals pin the model.
module tb_gray_counter_param;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       En = 1'b0;
    logic       Up = 1'b0;
    logic       Load = 1'b0;
    logic       ClrFlags = 1'b0;
    logic [7:0] LoadGray = 8'h0;

    always #5 Clk = ~Clk;

    logic [2:0] a_g, a_b, b_g, b_b;
    logic [7:0] c_g, c_b;
    logic [2:0] ov, un, wr;

    gray_counter_param #(.WIDTH(3), .WRAP(1'b1), .RESET_VAL(0)) u_a (
        .Clk(Clk), .Reset(Reset), .En(En), .Up(Up), .Load(Load),
        .LoadGray(LoadGray[2:0]), .ClrFlags(ClrFlags), .Output(a_g), .Binary(a_b),
        .Overflow(ov[0]), .Underflow(un[0]), .Wrap(wr[0]));

    gray_counter_param #(.WIDTH(3), .WRAP(1'b0), .RESET_VAL(2)) u_b (
        .Clk(Clk), .Reset(Reset), .En(En), .Up(Up), .Load(Load),
        .LoadGray(LoadGray[2:0]), .ClrFlags(ClrFlags), .Output(b_g), .Binary(b_b),
        .Overflow(ov[1]), .Underflow(un[1]), .Wrap(wr[1]));

    gray_counter_param #(.WIDTH(8), .WRAP(1'b1), .RESET_VAL(0)) u_c (
        .Clk(Clk), .Reset(Reset), .En(En), .Up(Up), .Load(Load),
        .LoadGray(LoadGray), .ClrFlags(ClrFlags), .Output(c_g), .Binary(c_b),
        .Overflow(ov[2]), .Underflow(un[2]), .Wrap(wr[2]));

    logic [7:0] d_b[3];
    logic [7:0] d_g[3];
    assign d_b[0] = {5'b0, a_b};
    assign d_b[1] = {5'b0, b_b};
    assign d_b[2] = c_b;
    assign d_g[0] = {5'b0, a_g};
    assign d_g[1] = {5'b0, b_g};
    assign d_g[2] = c_g;

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    int MW[3]  = '{3, 3, 8};
    bit MWR[3] = '{1'b1, 1'b0, 1'b1};
    int MRV[3] = '{0, 2, 0};

    int m_bin[3];
    bit m_ov[3], m_un[3], m_wr[3], m_cnt[3];

    // Gray decode by search: the binary value whose Gray image matches.
    function automatic int g2b(input int g, input int w);
        int r = 0;
        for (int v = 0; v < (1 << w); v++) begin
            if ((v ^ (v >> 1)) == g) r = v;
        end
        return r;
    endfunction

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int k = 0; k < 3; k++) begin
                m_bin[k] <= MRV[k];
                m_ov[k]  <= 1'b0;
                m_un[k]  <= 1'b0;
                m_wr[k]  <= 1'b0;
                m_cnt[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                int mx, nb;
                bit nov, nun, nwr, nc;
                mx  = (1 << MW[k]) - 1;
                nb  = m_bin[k];
                nov = ClrFlags ? 1'b0 : m_ov[k];
                nun = ClrFlags ? 1'b0 : m_un[k];
                nwr = 1'b0;
                nc  = 1'b0;
                if (Load) begin
                    nb = g2b(int'(LoadGray) & mx, MW[k]);
                end else if (En && Up) begin
                    if (nb == mx) begin
                        nov = 1'b1; nwr = 1'b1;
                        if (MWR[k]) begin nb = 0; nc = 1'b1; end
                    end else begin
                        nb = nb + 1; nc = 1'b1;
                    end
                end else if (En) begin
                    if (nb == 0) begin
                        nun = 1'b1; nwr = 1'b1;
                        if (MWR[k]) begin nb = mx; nc = 1'b1; end
                    end else begin
                        nb = nb - 1; nc = 1'b1;
                    end
                end
                m_bin[k] <= nb;
                m_ov[k]  <= nov;
                m_un[k]  <= nun;
                m_wr[k]  <= nwr;
                m_cnt[k] <= nc;
            end
        end
    end

    // ---------------- compare ----------------
    logic [7:0] prev_g[3];

    always @(negedge Clk) begin
        if (chk_on) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("bin[%0d]", k), int'(d_b[k]), m_bin[k]);
                check($sformatf("gray[%0d]", k), int'(d_g[k]), m_bin[k] ^ (m_bin[k] >> 1));
                check($sformatf("ovf[%0d]", k), int'(ov[k]), int'(m_ov[k]));
                check($sformatf("unf[%0d]", k), int'(un[k]), int'(m_un[k]));
                check($sformatf("wrap[%0d]", k), int'(wr[k]), int'(m_wr[k]));
                if (m_cnt[k])
                    check($sformatf("onebit[%0d]", k), $countones(d_g[k] ^ prev_g[k]), 1);
                prev_g[k] = d_g[k];
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit en, input bit up, input bit ld, input logic [7:0] lg,
                        input bit clr);
        En = en; Up = up; Load = ld; LoadGray = lg; ClrFlags = clr;
        @(posedge Clk);
        #1;
    endtask

    int ga[9] = '{0, 1, 3, 2, 6, 7, 5, 4, 0};
    int wrcnt;

    initial begin
        #1 Reset = 1'b1;
        #1;
        check("rst_a_bin", int'(a_b), 0);
        check("rst_a_gray", int'(a_g), 0);
        check("rst_b_bin", int'(b_b), 2);
        check("rst_b_gray", int'(b_g), 3);
        check("rst_flags", int'({ov, un, wr}), 0);
        chk_on = 1'b1;
        @(posedge Clk);
        @(posedge Clk);
        #1 Reset = 1'b0;

        // Count up through the full 3-bit sequence.
        wrcnt = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 1'b0, 8'h0, 1'b0);
            check($sformatf("up_a_gray%0d", i), int'(a_g), ga[i+1]);
            check($sformatf("up_b_bin%0d", i), int'(b_b), (3 + i > 7) ? 7 : 3 + i);
            check($sformatf("up_b_wrap%0d", i), int'(wr[1]), (i >= 5) ? 1 : 0);
            wrcnt += int'(wr[0]);
        end
        check("up_a_wrapcnt", wrcnt, 1);
        check("up_a_ovf", int'(ov[0]), 1);
        check("sat_b_gray", int'(b_g), 3'b100);
        check("sat_b_ovf", int'(ov[1]), 1);

        step(1'b0, 1'b0, 1'b0, 8'h0, 1'b1);
        check("clr_ovf", int'(ov[1:0]), 0);
        check("idle_wrap", int'(wr), 0);

        step(1'b1, 1'b0, 1'b0, 8'h0, 1'b0);
        check("dn_a_bin", int'(a_b), 7);
        check("dn_a_unf", int'(un[0]), 1);

        step(1'b0, 1'b0, 1'b0, 8'h0, 1'b1);
        check("clr_a_unf", int'(un[0]), 0);
        check("clr_a_bin", int'(a_b), 7);

        // Load during a terminal-up cycle: load wins, no flag.
        step(1'b1, 1'b1, 1'b1, 8'b110, 1'b0);
        check("ld_a_bin", int'(a_b), 4);
        check("ld_a_gray", int'(a_g), 3'b110);
        check("ld_a_ovf", int'(ov[0]), 0);
        check("ld_a_wrap", int'(wr[0]), 0);

        step(1'b1, 1'b0, 1'b0, 8'h0, 1'b0);
        check("ld_dn_bin", int'(a_b), 3);
        check("ld_dn_gray", int'(a_g), 3'b010);

        // Terminal up together with ClrFlags: set wins.
        step(1'b0, 1'b0, 1'b1, 8'b100, 1'b0);
        step(1'b1, 1'b1, 1'b0, 8'h0, 1'b1);
        check("setwins_ovf", int'(ov[0]), 1);
        check("setwins_bin", int'(a_b), 0);

        // Saturate at zero, then preset to 5 keeping the sticky underflow.
        step(1'b0, 1'b0, 1'b1, 8'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h0, 1'b0);
        check("satdn_b_bin", int'(b_b), 0);
        check("satdn_b_unf", int'(un[1]), 1);
        step(1'b0, 1'b0, 1'b1, 8'b111, 1'b0);
        check("pre_b_bin", int'(b_b), 5);
        check("pre_b_unf", int'(un[1]), 1);

        // Asynchronous reset between edges.
        #3 Reset = 1'b1;
        #1;
        check("arst_b_bin", int'(b_b), 2);
        check("arst_b_gray", int'(b_g), 3'b011);
        check("arst_flags", int'({ov, un}), 0);
        check("arst_a_bin", int'(a_b), 0);
        #2 Reset = 1'b0;
        step(1'b1, 1'b1, 1'b0, 8'h0, 1'b0);
        check("resume_b_bin", int'(b_b), 3);

        // Random traffic, checked by the model every cycle.
        for (int i = 0; i < 10000; i++) begin
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 31) == 0, 8'($urandom), $urandom_range(0, 15) == 0);
        end

        @(negedge Clk);
        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
